nvdla_dbb_stream_bridge: RTL and testbench
==========================================

Name: nvdla_dbb_stream_bridge

Overview:
- Parametrised bridge between the NVDLA DBB (AXI-like) interface and the two HWPE streamers: the sink streamer for writes and the source streamer for reads.
- Supports DBB data width = RATIO x stream width, multi-beat bursts, ID return and round-robin read/write arbitration.
- Serialises DBB write beats into stream words and assembles stream words into DBB read beats.
- Sits between the NVDLA DBB port and the hwpe streamer inside the NVDLA HWPE wrapper.

Parameters:
- DBB_DATA_W, 512, DBB data width; a power of two, >= STREAM_DATA_W.
- STREAM_DATA_W, 32, HWPE stream word width.
- ADDR_W, 32, address width.
- ID_W, 8, transaction ID width.
- LEN_W, 4, burst length field; beats = len+1.
- Derived: RATIO = DBB_DATA_W/STREAM_DATA_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous soft clear
- wr_req_valid_i / wr_req_ready_o  in/out  1/1  write-request handshake
- wr_req_addr_i, wr_req_len_i, wr_req_id_i  in  ADDR_W, LEN_W, ID_W  write-request fields
- wr_dat_valid_i / wr_dat_ready_o  in/out  1/1  write-data handshake
- wr_dat_data_i, wr_dat_strb_i, wr_dat_last_i  in  DBB_DATA_W, DBB_DATA_W/8, 1  write-data beat
- wr_rsp_valid_o / wr_rsp_ready_i, wr_rsp_id_o  out/in, out  1/1, ID_W  write response
- rd_req_valid_i / rd_req_ready_o, rd_req_addr_i, rd_req_len_i, rd_req_id_i  as for the write request
- rd_dat_valid_o / rd_dat_ready_i  out/in  1/1  read-data handshake
- rd_dat_data_o, rd_dat_id_o, rd_dat_last_o  out  DBB_DATA_W, ID_W, 1  read-data beat
- sink_start_o, sink_ready_i  out/in  1/1  sink streamer start / ready_start
- src_start_o, src_ready_i  out/in  1/1  source streamer start / ready_start
- str_base_addr_o, str_trans_size_o  out  ADDR_W, 32  streamer address-generator config, held for the whole transaction
- out_valid_o / out_ready_i, out_data_o, out_strb_o  out/in, out  1/1, STREAM_DATA_W, STREAM_DATA_W/8  stream to memory (write path)
- in_valid_i / in_ready_o, in_data_i  in/out, in  1/1, STREAM_DATA_W  stream from memory (read path)
- len_err_o  out  1  sticky flag: write burst length mismatch

Behaviour:
- Reset (rst_i high) and clear_i:
  - State goes to IDLE; all counters and buffers are emptied.
  - Every valid, ready, start and last output is 0; len_err_o is 0; data, id, addr and size outputs are 0.
  - An in-flight transaction is dropped with no response.
- FSM states: IDLE, WR_START, WR_DATA, WR_RESP, RD_START, RD_DATA, DRAIN.
- IDLE:
  - Only one request valid: that request is selected.
  - Both valid: a last-granted priority bit chooses, favouring the type not granted last. The bit resets to "read granted last", so write wins first.
- WR_START:
  - wr_req_ready_o = sink_ready_i for one cycle.
  - On handshake: latch id and len, sink_start_o = 1 for exactly that cycle, str_base_addr_o = addr, str_trans_size_o = (len+1)*RATIO. Next state is WR_DATA.
  - RD_START is symmetric, using src_start_o and src_ready_i.
- WR_DATA serialiser:
  - One DBB_DATA_W holding buffer. wr_dat_ready_o = buffer empty OR (last word handshaking this cycle), giving 1 stream word per cycle sustained.
  - Word k (k = 0..RATIO-1, LSB first) is data[k*SW +: SW] with strb[k*SW/8 +: SW/8].
  - out_valid_o stays asserted and out_data_o/out_strb_o stay stable until out_ready_i.
  - beat_cnt counts accepted beats.
  - wr_dat_last_i set on a beat with beat_cnt != len, or last missing on beat len: set len_err_o. The burst always ends after len+1 beats.
  - After the final word is accepted, go to WR_RESP.
- WR_RESP:
  - Wait for sink_ready_i (streamer finished), then wr_rsp_valid_o = 1 with the latched id.
  - Hold until wr_rsp_ready_i, then go to IDLE.
- RD_DATA deserialiser:
  - in_ready_o = buffer not full OR rd_dat handshake this cycle. Word k is written into slice k.
  - After RATIO words, rd_dat_valid_o = 1 with the latched id; rd_dat_last_o = (beat_cnt == len).
  - Output is held until rd_dat_ready_i. After the last beat is accepted, go to DRAIN.
- DRAIN: wait for src_ready_i, then go to IDLE.
- RATIO = 1: pass-through with a 1-beat buffer; the word index is constant 0.
- Latency: first out_valid_o 1 cycle after the first wr_dat handshake. rd_dat_valid_o 1 cycle after the RATIO-th in handshake.
- Request fields are sampled only at the handshake; later changes are ignored.

Test Plan:
- Single write, RATIO=16, len=0, data words 0..15 = 0x0..0xF, out_ready_i tied 1:
  - sink_start_o pulses once with trans_size=16;
  - out_data_o emits 0x0..0xF on 16 consecutive cycles;
  - wr_rsp_valid_o with id=0x5A after sink_ready_i.
- Read, len=1, in_data_i = incrementing 0..31:
  - two rd_dat beats; beat0 slice k = k, beat1 slice k = 16+k; rd_dat_last_o only on beat1; id echoed.
- Back-pressure: out_ready_i toggling 1010..., then rd_dat_ready_i low for 5 cycles:
  - no word lost or duplicated;
  - outputs stable while stalled;
  - in_ready_o drops once the buffer is full.
- Simultaneous write and read requests, twice:
  - order is write, read, write, read;
  - each start pulse lasts exactly 1 cycle.
- Write len=2 with wr_dat_last_i on beat 1:
  - len_err_o = 1 and sticky;
  - 48 words still emitted; response is still issued.
- rst_i asserted mid-WR_DATA (word 7), then a clear_i pulse in a separate run:
  - all outputs 0 next edge (asynchronously for rst_i);
  - a new request then completes normally.

Source files
------------

// File: rtl/nvdla_dbb_stream_bridge.sv
// Bridge between the NVDLA DBB port and the HWPE sink/source streamers.
// Write beats are split LSB-first into stream words; read stream words are
// packed back into DBB beats. One transaction is in flight at a time.
module nvdla_dbb_stream_bridge #(
  parameter int DBB_DATA_W    = 512,
  parameter int STREAM_DATA_W = 32,
  parameter int ADDR_W        = 32,
  parameter int ID_W          = 8,
  parameter int LEN_W         = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       wr_req_valid_i,
  output logic                       wr_req_ready_o,
  input  logic [ADDR_W-1:0]          wr_req_addr_i,
  input  logic [LEN_W-1:0]           wr_req_len_i,
  input  logic [ID_W-1:0]            wr_req_id_i,
  input  logic                       wr_dat_valid_i,
  output logic                       wr_dat_ready_o,
  input  logic [DBB_DATA_W-1:0]      wr_dat_data_i,
  input  logic [DBB_DATA_W/8-1:0]    wr_dat_strb_i,
  input  logic                       wr_dat_last_i,
  output logic                       wr_rsp_valid_o,
  input  logic                       wr_rsp_ready_i,
  output logic [ID_W-1:0]            wr_rsp_id_o,
  input  logic                       rd_req_valid_i,
  output logic                       rd_req_ready_o,
  input  logic [ADDR_W-1:0]          rd_req_addr_i,
  input  logic [LEN_W-1:0]           rd_req_len_i,
  input  logic [ID_W-1:0]            rd_req_id_i,
  output logic                       rd_dat_valid_o,
  input  logic                       rd_dat_ready_i,
  output logic [DBB_DATA_W-1:0]      rd_dat_data_o,
  output logic [ID_W-1:0]            rd_dat_id_o,
  output logic                       rd_dat_last_o,
  output logic                       sink_start_o,
  input  logic                       sink_ready_i,
  output logic                       src_start_o,
  input  logic                       src_ready_i,
  output logic [ADDR_W-1:0]          str_base_addr_o,
  output logic [31:0]                str_trans_size_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [STREAM_DATA_W-1:0]   out_data_o,
  output logic [STREAM_DATA_W/8-1:0] out_strb_o,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [STREAM_DATA_W-1:0]   in_data_i,
  output logic                       len_err_o
);

  localparam int RATIO = DBB_DATA_W / STREAM_DATA_W;
  localparam int SB    = STREAM_DATA_W / 8;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [LEN_W:0]   BCNT_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0] OCNT_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE, WR_START, WR_DATA, WR_RESP, RD_START, RD_DATA, DRAIN
  } state_e;

  state_e state_q, state_d;
  logic   last_rd_q;

  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       size_q;
  logic [LEN_W:0]    bcnt_q;   // write: beats accepted; read: beats assembled
  logic [LEN_W-1:0]  ocnt_q;   // read beats delivered
  logic              err_q;
  logic              rsp_q;

  logic [RATIO-1:0][STREAM_DATA_W-1:0] wbuf_q;
  logic [RATIO-1:0][SB-1:0]            wstrb_q;
  logic                                wfull_q;
  logic [IDX_W-1:0]                    widx_q;

  logic [RATIO-1:0][STREAM_DATA_W-1:0] rbuf_q;
  logic                                rfull_q;
  logic [IDX_W-1:0]                    ridx_q;

  logic [LEN_W:0] len_ext;
  logic wr_hs_req, rd_hs_req, beats_left;
  logic out_hs, wlast_word, wdat_hs, rd_hs, in_hs;
  logic [31:0] wr_size, rd_size;

  assign len_ext    = {1'b0, len_q};
  assign beats_left = (bcnt_q <= len_ext);
  assign wr_hs_req  = (state_q == WR_START) && wr_req_valid_i && sink_ready_i;
  assign rd_hs_req  = (state_q == RD_START) && rd_req_valid_i && src_ready_i;
  assign wr_size    = (32'(wr_req_len_i) + 32'd1) * 32'(RATIO);
  assign rd_size    = (32'(rd_req_len_i) + 32'd1) * 32'(RATIO);

  assign out_hs     = wfull_q && out_ready_i;
  assign wlast_word = out_hs && (widx_q == LAST_IDX);
  assign wdat_hs    = wr_dat_valid_i && wr_dat_ready_o;
  assign rd_hs      = rfull_q && rd_dat_ready_i;
  assign in_hs      = in_valid_i && in_ready_o;

  assign wr_req_ready_o   = (state_q == WR_START) && sink_ready_i;
  assign rd_req_ready_o   = (state_q == RD_START) && src_ready_i;
  assign sink_start_o     = wr_hs_req;
  assign src_start_o      = rd_hs_req;
  // Config is driven straight from the request on the start cycle, then held.
  assign str_base_addr_o  = wr_hs_req ? wr_req_addr_i : rd_hs_req ? rd_req_addr_i : base_q;
  assign str_trans_size_o = wr_hs_req ? wr_size : rd_hs_req ? rd_size : size_q;

  assign wr_dat_ready_o = (state_q == WR_DATA) && beats_left && (!wfull_q || wlast_word);
  assign out_valid_o    = wfull_q;
  assign out_data_o     = wbuf_q[widx_q];
  assign out_strb_o     = wstrb_q[widx_q];
  assign wr_rsp_valid_o = rsp_q;
  assign wr_rsp_id_o    = id_q;
  assign len_err_o      = err_q;

  assign in_ready_o     = (state_q == RD_DATA) && beats_left && (!rfull_q || rd_hs);
  assign rd_dat_valid_o = rfull_q;
  assign rd_dat_data_o  = rbuf_q;
  assign rd_dat_id_o    = id_q;
  assign rd_dat_last_o  = rfull_q && (ocnt_q == len_q);

  // State register and the round-robin "read was granted last" bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
    end else if (clear_i) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == WR_START) last_rd_q <= 1'b0;
      else if (state_q == IDLE && state_d == RD_START) last_rd_q <= 1'b1;
    end
  end

  // Next-state: arbitration in IDLE, then walk one transaction to completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_req_valid_i && (!rd_req_valid_i || last_rd_q)) state_d = WR_START;
        else if (rd_req_valid_i)                              state_d = RD_START;
      end
      WR_START: if (wr_hs_req)                   state_d = WR_DATA;
      WR_DATA:  if (wlast_word && !beats_left)   state_d = WR_RESP;
      WR_RESP:  if (rsp_q && wr_rsp_ready_i)     state_d = IDLE;
      RD_START: if (rd_hs_req)                   state_d = RD_DATA;
      RD_DATA:  if (rd_hs && rd_dat_last_o)      state_d = DRAIN;
      DRAIN:    if (src_ready_i)                 state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  // Datapath: request latch, write serialiser, read deserialiser, response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q <= '0; len_q <= '0; base_q <= '0; size_q <= '0;
      bcnt_q <= '0; ocnt_q <= '0; err_q <= 1'b0; rsp_q <= 1'b0;
      wbuf_q <= '0; wstrb_q <= '0; wfull_q <= 1'b0; widx_q <= '0;
      rbuf_q <= '0; rfull_q <= 1'b0; ridx_q <= '0;
    end else if (clear_i) begin
      id_q <= '0; len_q <= '0; base_q <= '0; size_q <= '0;
      bcnt_q <= '0; ocnt_q <= '0; err_q <= 1'b0; rsp_q <= 1'b0;
      wbuf_q <= '0; wstrb_q <= '0; wfull_q <= 1'b0; widx_q <= '0;
      rbuf_q <= '0; rfull_q <= 1'b0; ridx_q <= '0;
    end else begin
      if (wr_hs_req) begin
        id_q <= wr_req_id_i; len_q <= wr_req_len_i;
        base_q <= wr_req_addr_i; size_q <= wr_size;
        bcnt_q <= '0; ocnt_q <= '0;
      end else if (rd_hs_req) begin
        id_q <= rd_req_id_i; len_q <= rd_req_len_i;
        base_q <= rd_req_addr_i; size_q <= rd_size;
        bcnt_q <= '0; ocnt_q <= '0; ridx_q <= '0;
      end
      // A new beat replaces the buffer exactly when its last word leaves.
      if (wdat_hs) begin
        wbuf_q  <= wr_dat_data_i;
        wstrb_q <= wr_dat_strb_i;
        wfull_q <= 1'b1;
        widx_q  <= '0;
        bcnt_q  <= bcnt_q + BCNT_ONE;
        if (wr_dat_last_i != (bcnt_q == len_ext)) err_q <= 1'b1;
      end else if (out_hs) begin
        widx_q <= (widx_q == LAST_IDX) ? '0 : widx_q + IDX_ONE;
        if (widx_q == LAST_IDX) wfull_q <= 1'b0;
      end
      if (state_q == WR_RESP) begin
        if (!rsp_q && sink_ready_i)        rsp_q <= 1'b1;
        else if (rsp_q && wr_rsp_ready_i)  rsp_q <= 1'b0;
      end
      // Delivery first so a beat completing this cycle re-arms rfull_q.
      if (rd_hs) begin
        rfull_q <= 1'b0;
        ocnt_q  <= ocnt_q + OCNT_ONE;
      end
      if (in_hs) begin
        rbuf_q[ridx_q] <= in_data_i;
        ridx_q <= (ridx_q == LAST_IDX) ? '0 : ridx_q + IDX_ONE;
        if (ridx_q == LAST_IDX) begin
          rfull_q <= 1'b1;
          bcnt_q  <= bcnt_q + BCNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_nvdla_dbb_stream_bridge.sv
// Directed bench for nvdla_dbb_stream_bridge with default parameters (RATIO=16).
module tb_nvdla_dbb_stream_bridge;

  logic clk_i = 1'b0, rst_i, clear_i;
  logic wr_req_valid_i, wr_req_ready_o;
  logic [31:0] wr_req_addr_i; logic [3:0] wr_req_len_i; logic [7:0] wr_req_id_i;
  logic wr_dat_valid_i, wr_dat_ready_o, wr_dat_last_i;
  logic [511:0] wr_dat_data_i; logic [63:0] wr_dat_strb_i;
  logic wr_rsp_valid_o, wr_rsp_ready_i; logic [7:0] wr_rsp_id_o;
  logic rd_req_valid_i, rd_req_ready_o;
  logic [31:0] rd_req_addr_i; logic [3:0] rd_req_len_i; logic [7:0] rd_req_id_i;
  logic rd_dat_valid_o, rd_dat_ready_i, rd_dat_last_o;
  logic [511:0] rd_dat_data_o; logic [7:0] rd_dat_id_o;
  logic sink_start_o, sink_ready_i, src_start_o, src_ready_i;
  logic [31:0] str_base_addr_o, str_trans_size_o;
  logic out_valid_o, out_ready_i; logic [31:0] out_data_o; logic [3:0] out_strb_o;
  logic in_valid_i, in_ready_o; logic [31:0] in_data_i;
  logic len_err_o;

  int n_cmp = 0, n_bad = 0;
  int nc;

  always #5 clk_i = ~clk_i;

  nvdla_dbb_stream_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
    .wr_req_addr_i(wr_req_addr_i), .wr_req_len_i(wr_req_len_i), .wr_req_id_i(wr_req_id_i),
    .wr_dat_valid_i(wr_dat_valid_i), .wr_dat_ready_o(wr_dat_ready_o),
    .wr_dat_data_i(wr_dat_data_i), .wr_dat_strb_i(wr_dat_strb_i), .wr_dat_last_i(wr_dat_last_i),
    .wr_rsp_valid_o(wr_rsp_valid_o), .wr_rsp_ready_i(wr_rsp_ready_i), .wr_rsp_id_o(wr_rsp_id_o),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rd_req_addr_i(rd_req_addr_i), .rd_req_len_i(rd_req_len_i), .rd_req_id_i(rd_req_id_i),
    .rd_dat_valid_o(rd_dat_valid_o), .rd_dat_ready_i(rd_dat_ready_i),
    .rd_dat_data_o(rd_dat_data_o), .rd_dat_id_o(rd_dat_id_o), .rd_dat_last_o(rd_dat_last_o),
    .sink_start_o(sink_start_o), .sink_ready_i(sink_ready_i),
    .src_start_o(src_start_o), .src_ready_i(src_ready_i),
    .str_base_addr_o(str_base_addr_o), .str_trans_size_o(str_trans_size_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_strb_o(out_strb_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .len_err_o(len_err_o)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i); #1;
  endtask

  // Issue a request from IDLE and check the one-cycle start pulse and config.
  task automatic start(input bit wr, input logic [31:0] a, input logic [3:0] l, input logic [7:0] id);
    if (wr) begin wr_req_valid_i = 1; wr_req_addr_i = a; wr_req_len_i = l; wr_req_id_i = id; end
    else    begin rd_req_valid_i = 1; rd_req_addr_i = a; rd_req_len_i = l; rd_req_id_i = id; end
    step;
    chk("start_pulse", wr ? sink_start_o : src_start_o, 1);
    chk("other_start", wr ? src_start_o : sink_start_o, 0);
    chk("req_ready", wr ? wr_req_ready_o : rd_req_ready_o, 1);
    chk("trans_size", str_trans_size_o, (32'(l) + 1) * 16);
    chk("base_addr", str_base_addr_o, a);
    step;
    chk("start_once", wr ? sink_start_o : src_start_o, 0);
    if (wr) begin wr_req_valid_i = 0; wr_req_addr_i = ~a; wr_req_len_i = ~l; end
    else    begin rd_req_valid_i = 0; rd_req_addr_i = ~a; rd_req_len_i = ~l; end
    #1;
    chk("base_hold", str_base_addr_o, a);
    chk("size_hold", str_trans_size_o, (32'(l) + 1) * 16);
  endtask

  // Send nb beats (word k of beat b = base+16b+k, strb nibble = k) and collect the stream.
  task automatic wr_beats(input int nb, input int lastpos, input logic [31:0] base,
                          input bit toggle, output int ncyc);
    int bi, wi, c; bit stall; logic [31:0] pd; logic [511:0] d; logic [63:0] s;
    bi = 0; wi = 0; c = 0; stall = 0; pd = '0;
    while (wi < nb * 16 && c < 400) begin
      for (int k = 0; k < 16; k++) begin
        d[k*32 +: 32] = base + 32'(bi * 16 + k);
        s[k*4 +: 4]   = 4'(k);
      end
      wr_dat_valid_i = (bi < nb); wr_dat_data_i = d; wr_dat_strb_i = s;
      wr_dat_last_i  = (bi == lastpos);
      out_ready_i    = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      if (stall) begin
        chk("wr_hold_vld", out_valid_o, 1);
        chk("wr_hold_dat", out_data_o, pd);
      end
      if (out_valid_o && out_ready_i) begin
        chk("wr_word", out_data_o, base + 32'(wi));
        chk("wr_strb", out_strb_o, wi % 16);
        wi++;
      end
      stall = out_valid_o && !out_ready_i; pd = out_data_o;
      if (wr_dat_valid_i && wr_dat_ready_o) bi++;
      step; c++;
    end
    wr_dat_valid_i = 0; wr_dat_last_i = 0; out_ready_i = 1;
    chk("wr_count", wi, nb * 16);
    ncyc = c;
  endtask

  task automatic rsp(input logic [7:0] id);
    sink_ready_i = 1;
    step;
    chk("rsp_valid", wr_rsp_valid_o, 1);
    chk("rsp_id", wr_rsp_id_o, id);
    wr_rsp_ready_i = 1;
    step;
    wr_rsp_ready_i = 0;
    chk("rsp_done", wr_rsp_valid_o, 0);
  endtask

  // Feed nb*16 words base+n; optionally stall the first beat for 5 cycles.
  task automatic rd_beats(input int nb, input logic [31:0] base, input logic [7:0] id,
                          input bit stall, output int ncyc);
    int wi, bo, c, hold; logic [511:0] e;
    wi = 0; bo = 0; c = 0; hold = 0;
    while (bo < nb && c < 400) begin
      in_valid_i = (wi < nb * 16); in_data_i = base + 32'(wi);
      rd_dat_ready_i = !(stall && rd_dat_valid_o && hold < 5);
      #1;
      if (rd_dat_valid_o) begin
        for (int k = 0; k < 16; k++) e[k*32 +: 32] = base + 32'(bo * 16 + k);
        chk("rd_data", rd_dat_data_o, e);
        chk("rd_id", rd_dat_id_o, id);
        chk("rd_last", rd_dat_last_o, (bo == nb - 1));
        if (!rd_dat_ready_i) begin hold++; chk("rd_inrdy_full", in_ready_o, 0); end
        else bo++;
      end
      if (in_valid_i && in_ready_o) wi++;
      step; c++;
    end
    in_valid_i = 0; rd_dat_ready_i = 1;
    chk("rd_beats", bo, nb);
    if (stall) chk("rd_hold", hold, 5);
    ncyc = c;
    step;  // DRAIN -> IDLE
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; clear_i = 0;
    wr_req_valid_i = 0; wr_req_addr_i = 0; wr_req_len_i = 0; wr_req_id_i = 0;
    wr_dat_valid_i = 0; wr_dat_data_i = 0; wr_dat_strb_i = 0; wr_dat_last_i = 0;
    wr_rsp_ready_i = 0;
    rd_req_valid_i = 0; rd_req_addr_i = 0; rd_req_len_i = 0; rd_req_id_i = 0;
    rd_dat_ready_i = 1; sink_ready_i = 1; src_ready_i = 1;
    out_ready_i = 1; in_valid_i = 0; in_data_i = 0;
    step; step;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_wr_req_rdy", wr_req_ready_o, 0);
    chk("rst_rd_valid", rd_dat_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_len_err", len_err_o, 0);
    chk("rst_base", str_base_addr_o, 0);
    chk("rst_size", str_trans_size_o, 0);
    rst_i = 0;
    step;

    // single write, len=0, response waits for sink_ready_i
    start(1, 32'h1000, 4'd0, 8'h5A);
    sink_ready_i = 0;
    wr_beats(1, 0, 32'h0, 0, nc);
    chk("t1_cycles", nc, 17);
    step;
    chk("t1_rsp_wait", wr_rsp_valid_o, 0);
    rsp(8'h5A);

    // read, len=1, incrementing words
    start(0, 32'h2000, 4'd1, 8'h33);
    rd_beats(2, 32'h0, 8'h33, 0, nc);
    chk("t2_cycles", nc, 33);

    // back-pressure on both paths
    start(1, 32'h3000, 4'd0, 8'h11);
    wr_beats(1, 0, 32'h100, 1, nc);
    rsp(8'h11);
    start(0, 32'h3100, 4'd1, 8'h12);
    rd_beats(2, 32'h200, 8'h12, 1, nc);

    // simultaneous requests alternate write, read, write, read
    rd_req_valid_i = 1;
    start(1, 32'h6000, 4'd0, 8'hA1);
    wr_beats(1, 0, 32'h700, 0, nc);
    rsp(8'hA1);
    wr_req_valid_i = 1;
    start(0, 32'h6100, 4'd0, 8'hB1);
    rd_beats(1, 32'h800, 8'hB1, 0, nc);
    rd_req_valid_i = 1;
    start(1, 32'h6200, 4'd0, 8'hA2);
    wr_beats(1, 0, 32'h780, 0, nc);
    rsp(8'hA2);
    wr_req_valid_i = 1;
    start(0, 32'h6300, 4'd0, 8'hB2);
    wr_req_valid_i = 0;
    rd_beats(1, 32'h880, 8'hB2, 0, nc);

    // len=2 with early last: sticky error, full burst still streamed
    start(1, 32'h7000, 4'd2, 8'h77);
    wr_beats(3, 1, 32'h900, 0, nc);
    chk("t5_cycles", nc, 49);
    chk("t5_len_err", len_err_o, 1);
    rsp(8'h77);
    chk("t5_len_err_sticky", len_err_o, 1);

    // async reset while word 7 is on the stream
    start(1, 32'h3800, 4'd0, 8'h21);
    for (int k = 0; k < 16; k++) wr_dat_data_i[k*32 +: 32] = 32'(k);
    wr_dat_valid_i = 1; wr_dat_last_i = 1;
    step;
    wr_dat_valid_i = 0; wr_dat_last_i = 0;
    repeat (7) step;
    chk("t6_word7", out_data_o, 7);
    #2 rst_i = 1;
    #1;
    chk("t6_rst_out_valid", out_valid_o, 0);
    chk("t6_rst_len_err", len_err_o, 0);
    chk("t6_rst_base", str_base_addr_o, 0);
    chk("t6_rst_size", str_trans_size_o, 0);
    chk("t6_rst_dat_rdy", wr_dat_ready_o, 0);
    step;
    rst_i = 0;
    step;
    start(1, 32'h4000, 4'd0, 8'h22);
    wr_beats(1, 0, 32'hA00, 0, nc);
    rsp(8'h22);

    // clear_i mid-write after a length error, then a normal read
    start(1, 32'h4100, 4'd1, 8'h41);
    wr_dat_valid_i = 1; wr_dat_last_i = 1;
    step;
    wr_dat_valid_i = 0; wr_dat_last_i = 0;
    step; step;
    chk("t7_err_before", len_err_o, 1);
    clear_i = 1;
    step;
    clear_i = 0;
    chk("t7_clr_out_valid", out_valid_o, 0);
    chk("t7_clr_len_err", len_err_o, 0);
    chk("t7_clr_base", str_base_addr_o, 0);
    chk("t7_clr_dat_rdy", wr_dat_ready_o, 0);
    start(0, 32'h4200, 4'd0, 8'h42);
    rd_beats(1, 32'hB00, 8'h42, 0, nc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
